// File: rtl/ahb_lite_rif_bridge.sv
// AHB-Lite slave to register-interface bridge with wait-state handshake, byte strobes and ERROR response.
// Optional RIF wait timeout is compiled in with AHB_RIF_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no transfer in data phase, HREADYOUT=1
// RD    | read request to RIF; after RIF completion, registered data is returned
// WR    | write request to RIF, completes in the same cycle as rif_ready
// ERR1  | first ERROR cycle, HREADYOUT=0
// ERR2  | second ERROR cycle, HREADYOUT=1, may accept a new address phase
module ahb_lite_rif_bridge #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int SEC_TRANS      = 0,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int BYTE_COUNT     = DATA_WIDTH / 8
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [ADDR_WIDTH-1:0] HADDR,
   input  logic                  HSEL,
   input  logic                  HNONSEC,
   input  logic [2:0]            HSIZE,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [DATA_WIDTH-1:0] HWDATA,
   output logic [DATA_WIDTH-1:0] HRDATA,
   output logic                  HRESP,
   input  logic                  HREADYIN,
   output logic                  HREADYOUT,
   output logic [ADDR_WIDTH-1:0] rif_addr,
   output logic                  rif_wr_req,
   output logic                  rif_rd_req,
   output logic [BYTE_COUNT-1:0] rif_wstrb,
   output logic [DATA_WIDTH-1:0] rif_wdata,
   input  logic [DATA_WIDTH-1:0] rif_rdata,
   input  logic                  rif_ready,
   input  logic                  rif_addr_valid
);

   localparam int LANE_BITS = $clog2(BYTE_COUNT);

   if (!(DATA_WIDTH == 8 || DATA_WIDTH == 16 || DATA_WIDTH == 32 || DATA_WIDTH == 64 ||
         DATA_WIDTH == 128 || DATA_WIDTH == 256 || DATA_WIDTH == 512 || DATA_WIDTH == 1024)) begin : g_bad_width
      $fatal(1, "ahb_lite_rif_bridge: illegal DATA_WIDTH %0d", DATA_WIDTH);
   end
   if (BYTE_COUNT != DATA_WIDTH / 8) begin : g_bad_lanes
      $fatal(1, "ahb_lite_rif_bridge: BYTE_COUNT must equal DATA_WIDTH/8");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $fatal(1, "ahb_lite_rif_bridge: TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WR,
      ST_ERR1,
      ST_ERR2
   } state_t;

   state_t                  state_q, state_d, accept_state;
   logic                    rd_done_q, rd_done_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [BYTE_COUNT-1:0]   wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;

   logic                    hreadyout, hresp, rd_req, wr_req, accept;
   logic                    size_bad, misaligned, sec_bad, xfer_ok;
   logic [BYTE_COUNT-1:0]   new_strobe;
   logic [DATA_WIDTH-1:0]   rdata_masked;
   logic                    tmo_hit;

   function automatic logic [BYTE_COUNT-1:0] lane_strobe(input logic [ADDR_WIDTH-1:0] addr,
                                                         input logic [2:0] size);
      logic [BYTE_COUNT-1:0] s;
      int                    off;
      int                    nb;
      off = int'(addr & ADDR_WIDTH'(BYTE_COUNT - 1));
      nb  = 1 << size;
      s   = '0;
      for (int i = 0; i < BYTE_COUNT; i++) begin
         s[i] = (i >= off) && (i < off + nb);
      end
      return s;
   endfunction

   always_comb begin
      size_bad   = int'(HSIZE) > LANE_BITS;
      misaligned = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i < ADDR_WIDTH && i < int'(HSIZE) && HADDR[i]) begin
            misaligned = 1'b1;
         end
      end
      sec_bad      = (SEC_TRANS != 0) && HNONSEC;
      xfer_ok      = !size_bad && !misaligned && !sec_bad;
      new_strobe   = lane_strobe(HADDR, HSIZE);
      accept_state = !xfer_ok ? ST_ERR1 : (HWRITE ? ST_WR : ST_RD);
   end

   always_comb begin
      for (int i = 0; i < BYTE_COUNT; i++) begin
         rdata_masked[i*8 +: 8] = wstrb_q[i] ? rif_rdata[i*8 +: 8] : 8'h00;
      end
   end

`ifdef AHB_RIF_TIMEOUT_EN
   localparam int TMO_BITS_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TMO_BITS     = (TMO_BITS_RAW < 8) ? 8 : ((TMO_BITS_RAW > 32) ? 32 : TMO_BITS_RAW);

   logic [TMO_BITS-1:0] tmo_cnt_q, tmo_cnt_d;
   logic                rif_waiting;

   // Hit fires in the wait cycle that would bring the count to TIMEOUT_CYCLES.
   always_comb begin
      rif_waiting = ((state_q == ST_WR) || (state_q == ST_RD && !rd_done_q)) && !rif_ready;
      tmo_hit     = rif_waiting && (tmo_cnt_q == TMO_BITS'(TIMEOUT_CYCLES - 1));
      tmo_cnt_d   = (rif_waiting && !tmo_hit) ? tmo_cnt_q + 1'b1 : '0;
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      rd_done_d = 1'b0;
      addr_d    = addr_q;
      wstrb_d   = wstrb_q;
      hrdata_d  = hrdata_q;
      hreadyout = 1'b1;
      hresp     = 1'b0;
      rd_req    = 1'b0;
      wr_req    = 1'b0;

      case (state_q)
         ST_RD: begin
            hreadyout = rd_done_q;
            rd_req    = !rd_done_q;
         end
         ST_WR: begin
            hreadyout = rif_ready & rif_addr_valid;
            wr_req    = 1'b1;
         end
         ST_ERR1: begin
            hreadyout = 1'b0;
            hresp     = 1'b1;
         end
         ST_ERR2: begin
            hresp = 1'b1;
         end
         default: ;
      endcase

      accept = HSEL & HREADYIN & HTRANS[1] & hreadyout;

      case (state_q)
         ST_IDLE, ST_ERR2: begin
            state_d = accept ? accept_state : ST_IDLE;
         end
         ST_WR: begin
            if (rif_ready) begin
               if (rif_addr_valid) begin
                  state_d = accept ? accept_state : ST_IDLE;
               end else begin
                  state_d = ST_ERR1;
               end
            end else if (tmo_hit) begin
               state_d = ST_ERR1;
            end
         end
         ST_RD: begin
            if (rd_done_q) begin
               state_d = accept ? accept_state : ST_IDLE;
            end else if (rif_ready) begin
               if (rif_addr_valid) begin
                  rd_done_d = 1'b1;
                  hrdata_d  = rdata_masked;
               end else begin
                  state_d = ST_ERR1;
               end
            end else if (tmo_hit) begin
               state_d = ST_ERR1;
            end
         end
         ST_ERR1: begin
            state_d = ST_ERR2;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Strobes only live while a request can be held; cleared otherwise.
      if (accept) begin
         addr_d  = HADDR;
         wstrb_d = xfer_ok ? new_strobe : '0;
      end else if (state_d != ST_RD && state_d != ST_WR) begin
         wstrb_d = '0;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= ST_IDLE;
         rd_done_q <= 1'b0;
         addr_q    <= '0;
         wstrb_q   <= '0;
         hrdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         rd_done_q <= rd_done_d;
         addr_q    <= addr_d;
         wstrb_q   <= wstrb_d;
         hrdata_q  <= hrdata_d;
      end
   end

   assign HREADYOUT  = hreadyout;
   assign HRESP      = hresp;
   assign HRDATA     = hrdata_q;
   assign rif_addr   = addr_q;
   assign rif_wstrb  = wstrb_q;
   assign rif_rd_req = rd_req;
   assign rif_wr_req = wr_req;
   assign rif_wdata  = HWDATA;

endmodule

// File: tb/tb_ahb_lite_rif_bridge.sv
// Bench for ahb_lite_rif_bridge: directed and randomized transfers checked against a transfer-level model.
module tb_ahb_lite_rif_bridge;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic [11:0] HADDR;
   logic        HSEL;
   logic        HNONSEC;
   logic [2:0]  HSIZE;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HRESP;
   logic        HREADYIN;
   logic        HREADYOUT;
   logic [11:0] rif_addr;
   logic        rif_wr_req;
   logic        rif_rd_req;
   logic [3:0]  rif_wstrb;
   logic [31:0] rif_wdata;
   logic [31:0] rif_rdata;
   logic        rif_ready;
   logic        rif_addr_valid;

   int checks = 0;
   int errors = 0;

   always #5 HCLK = ~HCLK;

   ahb_lite_rif_bridge #(
      .ADDR_WIDTH(12), .DATA_WIDTH(32), .SEC_TRANS(1), .TIMEOUT_CYCLES(4)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HSEL(HSEL), .HNONSEC(HNONSEC),
      .HSIZE(HSIZE), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA),
      .HRESP(HRESP), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT), .rif_addr(rif_addr),
      .rif_wr_req(rif_wr_req), .rif_rd_req(rif_rd_req), .rif_wstrb(rif_wstrb),
      .rif_wdata(rif_wdata), .rif_rdata(rif_rdata), .rif_ready(rif_ready),
      .rif_addr_valid(rif_addr_valid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge HCLK);
   endtask

   task automatic bus_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
   endtask

   task automatic addr_phase(input logic [11:0] a, input logic [2:0] sz, input logic wr, input logic ns);
      HSEL    = 1'b1;
      HTRANS  = 2'b10;
      HADDR   = a;
      HSIZE   = sz;
      HWRITE  = wr;
      HNONSEC = ns;
   endtask

   // Transfer-level model: error decision, lane strobe and masked read data.
   function automatic logic model_bad(input logic [11:0] a, input logic [2:0] sz, input logic ns);
      return (sz > 3'd2) || ((int'(a) % (1 << sz)) != 0) || ns;
   endfunction

   function automatic logic [3:0] model_strb(input logic [11:0] a, input logic [2:0] sz);
      int s;
      s = ((1 << (1 << sz)) - 1) << (int'(a) % 4);
      return s[3:0];
   endfunction

   function automatic logic [31:0] model_rdata(input logic [3:0] strb, input logic [31:0] rd);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = rd[8*i +: 8];
      return r;
   endfunction

   task automatic check_err_pair(input string tag);
      chk({tag, "_err1_hready"}, 32'(HREADYOUT), 32'd0);
      chk({tag, "_err1_hresp"}, 32'(HRESP), 32'd1);
      chk({tag, "_err1_req"}, 32'({rif_wr_req, rif_rd_req}), 32'd0);
      next_cycle(); #1;
      chk({tag, "_err2_hready"}, 32'(HREADYOUT), 32'd1);
      chk({tag, "_err2_hresp"}, 32'(HRESP), 32'd1);
      chk({tag, "_err2_req"}, 32'({rif_wr_req, rif_rd_req}), 32'd0);
   endtask

   // One isolated transfer: address phase, then `waits` RIF wait cycles, then completion with av.
   task automatic xfer(input string tag, input logic [11:0] a, input logic [2:0] sz, input logic wr,
                       input logic ns, input logic [31:0] wd, input logic [31:0] rd,
                       input int waits, input logic av);
      logic       bad;
      logic [3:0] strb;
      bad  = model_bad(a, sz, ns);
      strb = model_strb(a, sz);
      next_cycle();
      addr_phase(a, sz, wr, ns);
      rif_ready = 1'b0;
      #1 chk({tag, "_accept"}, 32'(HREADYOUT), 32'd1);
      next_cycle();
      bus_idle();
      HWDATA = wd;
      if (bad) begin
         #1 check_err_pair(tag);
      end else begin
         for (int w = 0; w < waits; w++) begin
            #1;
            chk({tag, "_wait_hready"}, 32'(HREADYOUT), 32'd0);
            chk({tag, "_wait_req"}, 32'({rif_wr_req, rif_rd_req}), wr ? 32'd2 : 32'd1);
            next_cycle();
         end
         rif_ready      = 1'b1;
         rif_addr_valid = av;
         rif_rdata      = rd;
         #1;
         chk({tag, "_req"}, 32'({rif_wr_req, rif_rd_req}), wr ? 32'd2 : 32'd1);
         chk({tag, "_addr"}, 32'(rif_addr), 32'(a));
         chk({tag, "_strb"}, 32'(rif_wstrb), 32'(strb));
         if (wr) chk({tag, "_wdata"}, rif_wdata, wd);
         if (!av) begin
            chk({tag, "_nav_hready"}, 32'(HREADYOUT), 32'd0);
            next_cycle();
            rif_ready = 1'b0;
            #1 check_err_pair(tag);
         end else if (wr) begin
            chk({tag, "_wr_hready"}, 32'(HREADYOUT), 32'd1);
            chk({tag, "_wr_hresp"}, 32'(HRESP), 32'd0);
            next_cycle();
            rif_ready = 1'b0;
            #1 chk({tag, "_wr_drop"}, 32'(rif_wr_req), 32'd0);
         end else begin
            chk({tag, "_rd_wait"}, 32'(HREADYOUT), 32'd0);
            next_cycle();
            rif_ready = 1'b0;
            #1;
            chk({tag, "_rd_hready"}, 32'(HREADYOUT), 32'd1);
            chk({tag, "_rd_hresp"}, 32'(HRESP), 32'd0);
            chk({tag, "_rd_data"}, HRDATA, model_rdata(strb, rd));
            chk({tag, "_rd_drop"}, 32'(rif_rd_req), 32'd0);
         end
      end
      rif_ready      = 1'b0;
      rif_addr_valid = 1'b1;
   endtask

   initial begin
      logic [11:0] ra;
      logic [2:0]  rs;
      HRESETn = 1'b0;
      bus_idle();
      HADDR = '0; HSIZE = '0; HWRITE = 1'b0; HNONSEC = 1'b0; HWDATA = '0;
      HREADYIN = 1'b1; rif_rdata = '0; rif_ready = 1'b0; rif_addr_valid = 1'b1;
      #12;
      chk("rst_hready", 32'(HREADYOUT), 32'd1);
      chk("rst_hresp", 32'(HRESP), 32'd0);
      chk("rst_hrdata", HRDATA, 32'd0);
      chk("rst_req", 32'({rif_wr_req, rif_rd_req}), 32'd0);
      chk("rst_addr", 32'(rif_addr), 32'd0);
      chk("rst_strb", 32'(rif_wstrb), 32'd0);
      next_cycle();
      HRESETn = 1'b1;

      // BUSY transfer: zero-wait OKAY, no RIF activity.
      next_cycle();
      HSEL = 1'b1; HTRANS = 2'b01;
      #1 chk("busy_hready", 32'(HREADYOUT), 32'd1);
      next_cycle();
      bus_idle();
      #1 chk("busy_req", 32'({rif_wr_req, rif_rd_req, HRESP}), 32'd0);

      xfer("wword", 12'h010, 3'd2, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 0, 1'b1);
      xfer("rbyte", 12'h013, 3'd0, 1'b0, 1'b0, 32'h0, 32'h11223344, 0, 1'b1);
      xfer("whmis", 12'h001, 3'd1, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b1);
      xfer("wsz3", 12'h000, 3'd3, 1'b1, 1'b0, 32'h0, 32'h0, 0, 1'b1);
      xfer("rnav", 12'h040, 3'd2, 1'b0, 1'b0, 32'h0, 32'hCAFEF00D, 3, 1'b0);
      xfer("nsec", 12'h050, 3'd2, 1'b0, 1'b1, 32'h0, 32'h0, 0, 1'b1);
      xfer("rhalf", 12'h012, 3'd1, 1'b0, 1'b0, 32'h0, 32'hA1B2C3D4, 2, 1'b1);

      // Back-to-back: write 0x020 then read 0x024, no bubble.
      next_cycle();
      addr_phase(12'h020, 3'd2, 1'b1, 1'b0);
      #1 chk("b2b_acc1", 32'(HREADYOUT), 32'd1);
      next_cycle();
      addr_phase(12'h024, 3'd2, 1'b0, 1'b0);
      HWDATA = 32'h01020304; rif_ready = 1'b1; rif_addr_valid = 1'b1; rif_rdata = 32'h55667788;
      #1;
      chk("b2b_wreq", 32'(rif_wr_req), 32'd1);
      chk("b2b_waddr", 32'(rif_addr), 32'h020);
      chk("b2b_whready", 32'(HREADYOUT), 32'd1);
      next_cycle();
      bus_idle();
      #1;
      chk("b2b_rreq", 32'({rif_wr_req, rif_rd_req}), 32'd1);
      chk("b2b_raddr", 32'(rif_addr), 32'h024);
      chk("b2b_rwait", 32'(HREADYOUT), 32'd0);
      next_cycle();
      rif_ready = 1'b0;
      #1;
      chk("b2b_rhready", 32'(HREADYOUT), 32'd1);
      chk("b2b_rdata", HRDATA, 32'h55667788);

`ifdef AHB_RIF_TIMEOUT_EN
      next_cycle();
      addr_phase(12'h030, 3'd2, 1'b0, 1'b0);
      next_cycle();
      bus_idle();
      for (int w = 0; w < 4; w++) begin
         #1 chk("tmo_req", 32'(rif_rd_req), 32'd1);
         next_cycle();
      end
      #1 check_err_pair("tmo");
`endif

      // Reset in the middle of a waiting read.
      next_cycle();
      addr_phase(12'h060, 3'd2, 1'b0, 1'b0);
      next_cycle();
      bus_idle();
      next_cycle();
      #1 chk("mid_req", 32'(rif_rd_req), 32'd1);
      HRESETn = 1'b0;
      #1;
      chk("mid_rst_hready", 32'(HREADYOUT), 32'd1);
      chk("mid_rst_req", 32'({rif_wr_req, rif_rd_req}), 32'd0);
      chk("mid_rst_strb", 32'(rif_wstrb), 32'd0);
      next_cycle();
      HRESETn = 1'b1;

      for (int n = 0; n < 40; n++) begin
         ra = 12'($urandom_range(0, 4095));
         rs = 3'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) ra = ra & ~12'((1 << rs) - 1);
         xfer("rand", ra, rs, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
              $urandom, $urandom, $urandom_range(0, 3), ($urandom_range(0, 5) != 0));
      end

      next_cycle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
